bitwise_logic_pipe: RTL and testbench

- Parametrised, pipelined bitwise logic unit for the datapath ALU.
- Generalises the fixed 64-bit OR array to any WIDTH and eight selectable logic ops, including the ARM-style BIC/ORN/EON forms.
- Adds zero/negative flag generation and a two-stage valid/ready pipeline with backpressure.
- Sits between operand fetch and writeback/flag logic; sustains one operation per cycle.

---
 rtl/bitwise_logic_pipe.sv | 92 +++++++++
 tb/tb_bitwise_logic_pipe.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_logic_pipe.sv
// Two-stage valid/ready bitwise logic unit: eight per-bit ops with zero/negative flags.
// S1 captures operands, S2 captures the computed result and flags.
module bitwise_logic_pipe #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NOR  = 3'b011,
    OP_BIC  = 3'b100,
    OP_ORN  = 3'b101,
    OP_EON  = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_op;
  logic             s2_valid;
  logic             s1_ready;
  logic             s2_ready;
  logic [WIDTH-1:0] s1_res;

  // A stage may load when it is empty or its contents move on this edge.
  assign s2_ready  = !s2_valid | out_ready;
  assign s1_ready  = !s1_valid | s2_ready;
  assign in_ready  = s1_ready & reset;
  assign out_valid = s2_valid;

  always_comb begin
    s1_res = s1_b;
    unique case (s1_op)
      OP_AND:  s1_res = s1_a & s1_b;
      OP_OR:   s1_res = s1_a | s1_b;
      OP_XOR:  s1_res = s1_a ^ s1_b;
      OP_NOR:  s1_res = ~(s1_a | s1_b);
      OP_BIC:  s1_res = s1_a & ~s1_b;
      OP_ORN:  s1_res = s1_a | ~s1_b;
      OP_EON:  s1_res = s1_a ^ ~s1_b;
      OP_PASS: s1_res = s1_b;
      default: s1_res = s1_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_AND;
      s2_valid <= 1'b0;
      result   <= '0;
      flag_z   <= 1'b0;
      flag_n   <= 1'b0;
    end else begin
      if (s1_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_a  <= a;
          s1_b  <= b;
          s1_op <= op_e'(op);
        end
      end
      // Result/flags only change when a real operation advances, so they hold under stall.
      if (s2_ready) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          result <= s1_res;
          flag_z <= (s1_res == '0);
          flag_n <= s1_res[WIDTH-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Self-checking bench for bitwise_logic_pipe: golden-vector table, corner sequences,
// and randomized traffic against a truth-table reference with an in-order scoreboard.
module tb_bitwise_logic_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, flag_z, flag_n;
  logic [63:0] a, b, result;
  logic [2:0]  op;

  logic        v8, rdy8, ov8, ordy8, z8, n8;
  logic [7:0]  a8, b8, res8;
  logic [2:0]  op8;

  always #5 clk = ~clk;

  bitwise_logic_pipe #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_z(flag_z), .flag_n(flag_n)
  );

  bitwise_logic_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(v8), .in_ready(rdy8),
    .a(a8), .b(b8), .op(op8), .out_valid(ov8), .out_ready(ordy8),
    .result(res8), .flag_z(z8), .flag_n(n8)
  );

  typedef struct {
    logic [63:0] res;
    logic        z;
    logic        n;
    int          acc;
  } exp_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  op;
    logic [63:0] res;
    logic        z;
    logic        n;
  } vec_t;

  exp_t        q[$];
  vec_t        tbl[11];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic        post_rst = 1'b0;
  logic        rdone;
  logic [63:0] e_res;
  logic        e_z, e_n;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: each op is a 4-entry truth table indexed by {a_i, b_i}.
  function automatic logic [63:0] model(input logic [63:0] x, input logic [63:0] y,
                                        input logic [2:0] o);
    logic [31:0] tts;
    logic [3:0]  tt;
    logic [63:0] r;
    tts = {4'b1010, 4'b1001, 4'b1101, 4'b0100, 4'b0001, 4'b0110, 4'b1110, 4'b1000};
    tt  = tts[o*4 +: 4];
    for (int i = 0; i < 64; i++) r[i] = tt[{x[i], y[i]}];
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: checks handshake and data every cycle, tracks transfers at the next edge.
  always @(negedge clk) begin
    if (!reset) begin
      chk("in_ready_in_reset", 64'(in_ready), 64'd0);
      q.delete();
      post_rst = 1'b1;
    end else begin
      if (post_rst) begin
        chk("post_reset_result", result, 64'd0);
        chk("post_reset_flags", 64'({flag_z, flag_n}), 64'd0);
        post_rst = 1'b0;
      end
      chk("in_ready", 64'(in_ready), 64'((q.size() < 2) || out_ready));
      chk("out_valid", 64'(out_valid), 64'((q.size() > 0) && (cyc >= q[0].acc + 1)));
      if (out_valid && q.size() > 0) begin
        chk("result", result, q[0].res);
        chk("flag_z", 64'(flag_z), 64'(q[0].z));
        chk("flag_n", 64'(flag_n), 64'(q[0].n));
      end
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back('{res: e_res, z: e_z, n: e_n, acc: cyc + 1});
    end
  end

  // Called at posedge+1; returns at posedge+1 after the set is accepted.
  task automatic send(input logic [63:0] x, input logic [63:0] y, input logic [2:0] o,
                      input logic [63:0] r, input logic z, input logic n);
    int t;
    in_valid = 1'b1; a = x; b = y; op = o;
    e_res = r; e_z = z; e_n = n;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 60);
    chk("send_accepted", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [63:0] x, input logic [63:0] y, input logic [2:0] o);
    logic [63:0] r;
    r = model(x, y, o);
    send(x, y, o, r, r == 64'd0, r[63]);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 60) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk);
    #1 chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  function automatic logic [63:0] rnd64();
    if ($urandom_range(7) == 0) return 64'd0;
    return {$urandom, $urandom};
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{64'h5, 64'h9, 3'b001, 64'hD, 1'b0, 1'b0};
    tbl[1]  = '{64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 3'b000, 64'h0F0F_0000_0F0F_0000, 1'b0, 1'b0};
    tbl[2]  = '{64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 3'b001, 64'hFFFF_0F0F_FFFF_0F0F, 1'b0, 1'b1};
    tbl[3]  = '{64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 3'b010, 64'hF0F0_0F0F_F0F0_0F0F, 1'b0, 1'b1};
    tbl[4]  = '{64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 3'b011, 64'h0000_F0F0_0000_F0F0, 1'b0, 1'b0};
    tbl[5]  = '{64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 3'b100, 64'hF0F0_0000_F0F0_0000, 1'b0, 1'b1};
    tbl[6]  = '{64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 3'b101, 64'hFFFF_F0F0_FFFF_F0F0, 1'b0, 1'b1};
    tbl[7]  = '{64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 3'b110, 64'h0F0F_F0F0_0F0F_F0F0, 1'b0, 1'b0};
    tbl[8]  = '{64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 3'b111, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b0};
    tbl[9]  = '{64'h0, 64'h0, 3'b001, 64'h0, 1'b1, 1'b0};
    tbl[10] = '{64'h8000_0000_0000_0000, 64'h0, 3'b001, 64'h8000_0000_0000_0000, 1'b0, 1'b1};

    reset = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;
    e_res = '0; e_z = 1'b0; e_n = 1'b0;
    v8 = 1'b0; a8 = '0; b8 = '0; op8 = '0; ordy8 = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // WIDTH=8 instance: EON then NOR back-to-back.
    v8 = 1'b1; a8 = 8'hA5; b8 = 8'h0F; op8 = 3'b110;
    @(negedge clk) chk("w8_in_ready", 64'(rdy8), 64'd1);
    @(posedge clk) #1 op8 = 3'b011;
    @(negedge clk) chk("w8_not_yet_valid", 64'(ov8), 64'd0);
    @(posedge clk) #1 v8 = 1'b0;
    @(negedge clk);
    chk("w8_eon_valid", 64'(ov8), 64'd1);
    chk("w8_eon_result", 64'(res8), 64'h55);
    chk("w8_eon_flags", 64'({z8, n8}), 64'd0);
    @(negedge clk);
    chk("w8_nor_valid", 64'(ov8), 64'd1);
    chk("w8_nor_result", 64'(res8), 64'h50);
    chk("w8_nor_flags", 64'({z8, n8}), 64'd0);
    @(posedge clk) #1;

    // Golden table: basic OR, op sweep back-to-back, flag corners.
    for (int i = 0; i < 11; i++)
      send(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].res, tbl[i].z, tbl[i].n);
    drain();

    // Backpressure: 4 sets offered while the consumer stalls for 5 cycles.
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++) send_m(rnd64(), rnd64(), 3'($urandom_range(7)));
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two operations in flight; an offer during reset must be ignored.
    out_ready = 1'b0;
    send_m(64'h1234, 64'h00FF, 3'b001);
    send_m(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 3'b010);
    reset = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; a = 64'hDEAD; b = 64'hBEEF; op = 3'b001;
    @(posedge clk);
    #1 reset = 1'b1; in_valid = 1'b0;
    send_m(64'h00F0, 64'h0FF0, 3'b100);
    drain();

    // Randomized traffic with random consumer stalls.
    rdone = 1'b0;
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          if ($urandom_range(3) == 0) begin
            @(posedge clk);
            #1;
          end else begin
            send_m(rnd64(), rnd64(), 3'($urandom_range(7)));
          end
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
